// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, LSB first.
// The serial line is double-flopped into the clk domain, a falling edge
// starts a frame, and every bit is sampled at its centre. A good frame
// updates data with a one-cycle rx_valid strobe; a low stop bit gives a
// one-cycle frame_err strobe and leaves data untouched.
module uart_rx #(
  parameter int BAUD_RATE   = 115_200,
  parameter int CLOCK_SPEED = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int BAUD_WIDTH = CLOCK_SPEED / BAUD_RATE;
  localparam int HALF_WIDTH = BAUD_WIDTH / 2;
  localparam int CNT_W      = (BAUD_WIDTH > 1) ? $clog2(BAUD_WIDTH) : 1;

  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_WIDTH - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Synchroniser chain plus the extra stage used for edge detection.
  logic rx_meta_q;
  logic rx_s_q;
  logic rx_prev_q;

  state_t           state_q,     state_d;
  logic [CNT_W-1:0] clk_cnt_q,   clk_cnt_d;
  logic [2:0]       bit_idx_q,   bit_idx_d;
  logic [7:0]       shift_q,     shift_d;
  logic [7:0]       data_q,      data_d;
  logic             rx_valid_q,  rx_valid_d;
  logic             frame_err_q, frame_err_d;

  // Bring rx into the clk domain; flops reset high to match the idle line,
  // so leaving reset never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      clk_cnt_q   <= '0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'h00;
      data_q      <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Next-state logic: count to each bit centre and sample the line there.
  always_comb begin
    state_d     = state_q;
    clk_cnt_d   = clk_cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        // Only a real high->low transition starts a frame; a line that is
        // already low (break, or after a framing error) is ignored.
        if (rx_prev_q && !rx_s_q) begin
          state_d   = START;
          clk_cnt_d = '0;
        end
      end

      START: begin
        if (clk_cnt_q == HALF_LAST) begin
          clk_cnt_d = '0;
          if (rx_s_q) begin
            // Line went back high before mid start bit: treat as a glitch.
            state_d = IDLE;
          end else begin
            state_d   = DATA;
            bit_idx_d = 3'd0;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_ONE;
        end
      end

      DATA: begin
        if (clk_cnt_q == BAUD_LAST) begin
          clk_cnt_d          = '0;
          shift_d[bit_idx_q] = rx_s_q;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_ONE;
        end
      end

      STOP: begin
        if (clk_cnt_q == BAUD_LAST) begin
          clk_cnt_d = '0;
          // Return to IDLE at the stop-bit centre so a start bit that
          // follows immediately is still seen as a falling edge.
          state_d   = IDLE;
          if (rx_s_q) begin
            data_d     = shift_q;
            rx_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign data      = data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx at 10 clk cycles per bit.
// A behavioural transmitter drives rx; a monitor logs every strobe, and
// each test compares the log against the frames it sent.
module tb_uart_rx;

  localparam int BW      = 10;
  localparam int HW      = BW / 2;
  localparam int LAT_MIN = HW + 9 * BW + 3;
  localparam int LAT_MAX = HW + 9 * BW + 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  uart_rx #(
    .BAUD_RATE  (100_000),
    .CLOCK_SPEED(1_000_000)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .data     (data),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         is_err;
    logic [7:0] d;
    int         cyc;
  } ev_t;

  ev_t evq[$];
  bit  both_seen = 1'b0;

  // Log every strobe seen away from the active edge.
  always @(negedge clk) begin
    if (rx_valid && frame_err) both_seen = 1'b1;
    if (rx_valid)  evq.push_back('{is_err: 1'b0, d: data, cyc: cyc});
    if (frame_err) evq.push_back('{is_err: 1'b1, d: data, cyc: cyc});
  end

  int         checks    = 0;
  int         errors    = 0;
  logic [7:0] last_good = 8'h00;
  int         fall_cyc  = 0;

  // All drive tasks start and end 1 time unit after a rising edge.
  task automatic drive_bit(input logic v);
    rx = v;
    repeat (BW) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    fall_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (data !== 8'h00)    begin errors++; $display("FAIL reset_data: got %h expected 00", data); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    rst = 1'b0;
    idle(5);
    $display("test_reset: data=%h busy=%b", data, busy);
  endtask

  task automatic test_single;
    evq.delete();
    send_frame(8'hA5, 1'b1);
    idle(20);
    checks++; if (evq.size() !== 1) begin errors++; $display("FAIL single_count: got %0d events expected 1", evq.size()); end
    if (evq.size() >= 1) begin
      checks++; if (evq[0].is_err !== 1'b0) begin errors++; $display("FAIL single_kind: got frame_err expected rx_valid"); end
      checks++; if (evq[0].d !== 8'hA5) begin errors++; $display("FAIL single_data: got %h expected a5", evq[0].d); end
      checks++;
      if ((evq[0].cyc - fall_cyc) < LAT_MIN || (evq[0].cyc - fall_cyc) > LAT_MAX) begin
        errors++;
        $display("FAIL single_latency: got %0d expected %0d..%0d", evq[0].cyc - fall_cyc, LAT_MIN, LAT_MAX);
      end
    end
    checks++; if (data !== 8'hA5) begin errors++; $display("FAIL single_hold: got %h expected a5", data); end
    last_good = 8'hA5;
    $display("test_single: sent a5, events=%0d data=%h", evq.size(), data);
  endtask

  task automatic test_back_to_back;
    evq.delete();
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle(20);
    checks++; if (evq.size() !== 2) begin errors++; $display("FAIL b2b_count: got %0d events expected 2", evq.size()); end
    if (evq.size() >= 2) begin
      checks++; if (evq[0].is_err || evq[1].is_err) begin errors++; $display("FAIL b2b_kind: got frame_err expected rx_valid"); end
      checks++; if (evq[0].d !== 8'h00) begin errors++; $display("FAIL b2b_data0: got %h expected 00", evq[0].d); end
      checks++; if (evq[1].d !== 8'hFF) begin errors++; $display("FAIL b2b_data1: got %h expected ff", evq[1].d); end
      checks++; if (evq[1].cyc - evq[0].cyc !== 10 * BW) begin errors++; $display("FAIL b2b_spacing: got %0d expected %0d", evq[1].cyc - evq[0].cyc, 10 * BW); end
    end
    last_good = 8'hFF;
    $display("test_back_to_back: sent 00,ff events=%0d data=%h", evq.size(), data);
  endtask

  task automatic test_frame_err;
    evq.delete();
    send_frame(8'h3C, 1'b0);
    idle(20);
    checks++; if (evq.size() !== 1) begin errors++; $display("FAIL ferr_count: got %0d events expected 1", evq.size()); end
    if (evq.size() >= 1) begin
      checks++; if (evq[0].is_err !== 1'b1) begin errors++; $display("FAIL ferr_kind: got rx_valid expected frame_err"); end
    end
    checks++; if (data !== last_good) begin errors++; $display("FAIL ferr_data_hold: got %h expected %h", data, last_good); end
    $display("test_frame_err: sent 3c with low stop, events=%0d data=%h", evq.size(), data);
  endtask

  task automatic test_glitch;
    int busy_cycles;
    evq.delete();
    busy_cycles = 0;
    rx = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (busy) busy_cycles++;
    end
    @(posedge clk);
    #1;
    checks++; if (busy_cycles < 4 || busy_cycles > 6) begin errors++; $display("FAIL glitch_busy: got %0d cycles expected 4..6", busy_cycles); end
    checks++; if (evq.size() !== 0) begin errors++; $display("FAIL glitch_strobe: got %0d events expected 0", evq.size()); end
    checks++; if (data !== last_good) begin errors++; $display("FAIL glitch_data: got %h expected %h", data, last_good); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_idle: got busy=%b expected 0", busy); end
    $display("test_glitch: busy for %0d cycles, events=%0d", busy_cycles, evq.size());
  endtask

  task automatic test_reset_midframe;
    logic [7:0] b;
    b = 8'h81;
    evq.delete();
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b[i]);
    rx = b[4];
    repeat (HW) @(posedge clk);
    #1;
    rst = 1'b1;
    rx  = 1'b1;
    #1;
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL rstmid_data: got %h expected 00", data); end
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    last_good = 8'h00;
    idle(20);
    checks++; if (evq.size() !== 0) begin errors++; $display("FAIL rstmid_strobe: got %0d events expected 0", evq.size()); end
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL rstmid_after: got %h expected 00", data); end
    send_frame(b, 1'b1);
    idle(20);
    checks++; if (evq.size() !== 1) begin errors++; $display("FAIL rstmid_resend_count: got %0d events expected 1", evq.size()); end
    if (evq.size() >= 1) begin
      checks++; if (evq[0].is_err || evq[0].d !== 8'h81) begin errors++; $display("FAIL rstmid_resend_data: got %h err=%b expected 81", evq[0].d, evq[0].is_err); end
    end
    last_good = 8'h81;
    $display("test_reset_midframe: resent 81, events=%0d data=%h", evq.size(), data);
  endtask

  task automatic test_random;
    logic [7:0] exp_q[$];
    logic [7:0] b;
    int         gap;
    int         n_err;
    evq.delete();
    for (int i = 0; i < 256; i++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      send_frame(b, 1'b1);
      gap = $urandom_range(0, 3);
      if (gap > 0) idle(gap);
    end
    idle(20);
    n_err = 0;
    foreach (evq[i]) if (evq[i].is_err) n_err++;
    checks++; if (n_err !== 0) begin errors++; $display("FAIL random_frame_err: got %0d expected 0", n_err); end
    checks++; if (evq.size() !== exp_q.size()) begin errors++; $display("FAIL random_count: got %0d expected %0d", evq.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < evq.size(); i++) begin
      checks++;
      if (evq[i].d !== exp_q[i]) begin
        errors++;
        $display("FAIL random_byte%0d: got %h expected %h", i, evq[i].d, exp_q[i]);
      end
    end
    $display("test_random: sent %0d bytes, received %0d", exp_q.size(), evq.size());
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_frame_err();
    test_glitch();
    test_reset_midframe();
    test_random();
    checks++; if (both_seen !== 1'b0) begin errors++; $display("FAIL strobe_overlap: got rx_valid and frame_err together expected never"); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
